// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
// The FETCH_ALIGN_TRAP_EN macro is consumed by pc_next_sel and fetch_unit, not here.
package fetch_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned INSTRET_W = 32;
  localparam logic [WORD_SIZE-1:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

  // Clear the byte-offset bits so the address points at a whole instruction word.
  function automatic logic [WORD_SIZE-1:0] word_align(input logic [WORD_SIZE-1:0] a);
    return a & ~WORD_SIZE'(3);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Control, redirect and instruction-memory signals between the core and fetch_unit.
interface fetch_if;
  import fetch_pkg::*;

  logic                   i_stall;
  logic                   i_jump;
  logic [WORD_SIZE-1:0]   i_jump_target;
  logic                   i_branch_taken;
  logic [WORD_SIZE-1:0]   i_branch_target;
  logic                   i_halt;
  logic                   i_resume;
  logic [WORD_SIZE-1:0]   i_instr;
  logic [WORD_SIZE-1:0]   o_pc;
  logic [WORD_SIZE-1:0]   o_pc_plus4;
  logic [WORD_SIZE-1:0]   o_instr;
  logic                   o_valid;
  logic                   o_halted;
  logic [INSTRET_W-1:0]   o_instret;
  logic                   o_misaligned;

  modport slave (
    input  i_stall, i_jump, i_jump_target, i_branch_taken, i_branch_target,
           i_halt, i_resume, i_instr,
    output o_pc, o_pc_plus4, o_instr, o_valid, o_halted, o_instret, o_misaligned
  );

  modport master (
    output i_stall, i_jump, i_jump_target, i_branch_taken, i_branch_target,
           i_halt, i_resume, i_instr,
    input  o_pc, o_pc_plus4, o_instr, o_valid, o_halted, o_instret, o_misaligned
  );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority mux and redirect alignment handling.
// FETCH_ALIGN_TRAP_EN: misaligned redirects go to TRAP_VECTOR instead of being word-aligned.
module pc_next_sel
  import fetch_pkg::*;
`ifdef FETCH_ALIGN_TRAP_EN
#(
  parameter logic [WORD_SIZE-1:0] TRAP_VECTOR = 32'h00000100
)
`endif
(
  input  fetch_state_t          i_state,
  input  logic [WORD_SIZE-1:0]  i_pc,
  input  logic                  i_stall,
  input  logic                  i_jump,
  input  logic [WORD_SIZE-1:0]  i_jump_target,
  input  logic                  i_branch_taken,
  input  logic [WORD_SIZE-1:0]  i_branch_target,
  input  logic                  i_halt,
  input  logic                  i_resume,
  output logic [WORD_SIZE-1:0]  o_pc_plus4,
  output logic [WORD_SIZE-1:0]  o_next_pc,
  output logic                  o_advance,
  output logic                  o_trap
);

  logic                 w_redirect;
  logic [WORD_SIZE-1:0] w_target;

  assign o_pc_plus4 = i_pc + WORD_SIZE'(4);

  // Jump outranks a taken branch when both arrive in the same cycle.
  always_comb begin
    w_redirect = 1'b0;
    w_target   = i_jump_target;
    if (i_jump) begin
      w_redirect = 1'b1;
    end else if (i_branch_taken) begin
      w_redirect = 1'b1;
      w_target   = i_branch_target;
    end
  end

  always_comb begin
    o_next_pc = i_pc;
    o_advance = 1'b0;
    o_trap    = 1'b0;
    unique case (i_state)
      ST_RUN: begin
        if (!i_halt && !i_stall) begin
          o_advance = 1'b1;
          if (w_redirect) begin
`ifdef FETCH_ALIGN_TRAP_EN
            if (w_target[1:0] != 2'b00) begin
              o_next_pc = TRAP_VECTOR;
              o_trap    = 1'b1;
            end else begin
              o_next_pc = w_target;
            end
`else
            o_next_pc = word_align(w_target);
`endif
          end else begin
            o_next_pc = o_pc_plus4;
          end
        end
      end
      // Resume wins over a simultaneous halt; stall has no effect while halted.
      ST_HALT: begin
        if (i_resume) begin
          o_next_pc = o_pc_plus4;
          o_advance = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register, boot/run/halt sequencing and retired-fetch counter for the single-cycle core.
// FETCH_ALIGN_TRAP_EN enables trapping on misaligned redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [WORD_SIZE-1:0] RESET_VECTOR = 32'h00000000,
  parameter logic [WORD_SIZE-1:0] TRAP_VECTOR  = 32'h00000100,
  parameter int unsigned          BOOT_WAIT    = 2
) (
  input  logic     i_clk,
  input  logic     i_rst,
  fetch_if.slave   bus
);

  localparam int unsigned BOOT_W = (BOOT_WAIT > 2) ? $clog2(BOOT_WAIT) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'((BOOT_WAIT == 0) ? 0 : BOOT_WAIT - 1);
  localparam fetch_state_t RESET_STATE = (BOOT_WAIT == 0) ? ST_RUN : ST_BOOT;

  // The trap target must itself be a legal fetch address.
  if (TRAP_VECTOR[1:0] != 2'b00) begin : g_bad_trap_vector
    $error("fetch_unit: TRAP_VECTOR must be word-aligned");
  end

  fetch_state_t          r_state;
  fetch_state_t          w_state_nxt;
  logic [BOOT_W-1:0]     r_boot_cnt;
  logic [BOOT_W-1:0]     w_boot_cnt_nxt;
  logic [WORD_SIZE-1:0]  r_pc;
  logic [INSTRET_W-1:0]  r_instret;
  logic                  r_misaligned;

  logic [WORD_SIZE-1:0]  w_pc_plus4;
  logic [WORD_SIZE-1:0]  w_next_pc;
  logic                  w_advance;
  logic                  w_trap;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= RESET_STATE;
      r_boot_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_boot_cnt <= w_boot_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_boot_cnt_nxt = r_boot_cnt;
    unique case (r_state)
      ST_BOOT: begin
        if (r_boot_cnt == BOOT_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_boot_cnt_nxt = r_boot_cnt + BOOT_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.i_halt) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (bus.i_resume) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = RESET_STATE;
    endcase
  end

`ifdef FETCH_ALIGN_TRAP_EN
  pc_next_sel #(.TRAP_VECTOR(TRAP_VECTOR)) u_next_sel (
`else
  pc_next_sel u_next_sel (
`endif
    .i_state         (r_state),
    .i_pc            (r_pc),
    .i_stall         (bus.i_stall),
    .i_jump          (bus.i_jump),
    .i_jump_target   (bus.i_jump_target),
    .i_branch_taken  (bus.i_branch_taken),
    .i_branch_target (bus.i_branch_target),
    .i_halt          (bus.i_halt),
    .i_resume        (bus.i_resume),
    .o_pc_plus4      (w_pc_plus4),
    .o_next_pc       (w_next_pc),
    .o_advance       (w_advance),
    .o_trap          (w_trap)
  );

  // w_trap is constant 0 unless the trap option is built in, so o_misaligned stays low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc         <= RESET_VECTOR;
      r_instret    <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_pc         <= w_next_pc;
      r_misaligned <= w_trap;
      if (w_advance) begin
        r_instret <= r_instret + INSTRET_W'(1);
      end
    end
  end

  assign bus.o_pc         = r_pc;
  assign bus.o_pc_plus4   = w_pc_plus4;
  assign bus.o_valid      = (r_state == ST_RUN);
  assign bus.o_halted     = (r_state == ST_HALT);
  assign bus.o_instr      = (r_state == ST_RUN) ? bus.i_instr : NOP_INSTR;
  assign bus.o_instret    = r_instret;
  assign bus.o_misaligned = r_misaligned;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: reference model feeds a scoreboard, outputs compared after each edge.
module tb_fetch_unit;
  import fetch_pkg::*;

`ifdef FETCH_ALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam int unsigned BW = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        halted;
    logic [31:0] instret;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch_unit #(
    .RESET_VECTOR (32'h00000000),
    .TRAP_VECTOR  (32'h00000100),
    .BOOT_WAIT    (BW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [31:0] mem [256];
  assign bus.i_instr = mem[bus.o_pc[9:2]];

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  fetch_state_t m_st;
  logic [31:0]  m_pc;
  logic [31:0]  m_ir;
  int           m_boot;
  logic         m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = ST_BOOT; m_pc = 32'h0; m_ir = 32'h0; m_boot = 0; m_mis = 1'b0;
  endtask

  task automatic drive(input logic st, input logic jp, input logic [31:0] jt,
                       input logic br, input logic [31:0] bt, input logic hl, input logic rs);
    bus.i_stall = st; bus.i_jump = jp; bus.i_jump_target = jt;
    bus.i_branch_taken = br; bus.i_branch_target = bt;
    bus.i_halt = hl; bus.i_resume = rs;
  endtask

  // Advance the reference model by one clock using the currently driven inputs.
  task automatic model_step();
    logic [31:0] t;
    logic        red;
    exp_t        e;
    m_mis = 1'b0;
    case (m_st)
      ST_BOOT: if (m_boot == BW - 1) m_st = ST_RUN; else m_boot++;
      ST_RUN: begin
        if (bus.i_halt) m_st = ST_HALT;
        else if (!bus.i_stall) begin
          red = bus.i_jump | bus.i_branch_taken;
          t   = bus.i_jump ? bus.i_jump_target : bus.i_branch_target;
          if (!red) m_pc = m_pc + 32'd4;
          else if (TRAP_EN && t[1:0] != 2'b00) begin m_pc = 32'h100; m_mis = 1'b1; end
          else m_pc = {t[31:2], 2'b00};
          m_ir = m_ir + 32'd1;
        end
      end
      ST_HALT: if (bus.i_resume) begin m_pc = m_pc + 32'd4; m_ir = m_ir + 32'd1; m_st = ST_RUN; end
      default: ;
    endcase
    e.pc = m_pc; e.valid = (m_st == ST_RUN); e.halted = (m_st == ST_HALT);
    e.instr = e.valid ? mem[m_pc[9:2]] : 32'h00000013;
    e.instret = m_ir; e.mis = m_mis;
    sb.push_back(e);
  endtask

  task automatic cycle(input logic st, input logic jp, input logic [31:0] jt,
                       input logic br, input logic [31:0] bt, input logic hl, input logic rs);
    exp_t e;
    drive(st, jp, jt, br, bt, hl, rs);
    model_step();
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("pc", bus.o_pc, e.pc);
      check("pc_plus4", bus.o_pc_plus4, e.pc + 32'd4);
      check("instr", bus.o_instr, e.instr);
      check("valid", 32'(bus.o_valid), 32'(e.valid));
      check("halted", 32'(bus.o_halted), 32'(e.halted));
      check("instret", bus.o_instret, e.instret);
      check("misaligned", 32'(bus.o_misaligned), 32'(e.mis));
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = (32'(i) << 20) | 32'h00000093;
    mem[1]  = 32'hf00015b7;
    mem[11] = 32'h001c0c13;
    model_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #12;
    check("rst_pc", bus.o_pc, 32'h0);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_instr", bus.o_instr, 32'h00000013);
    check("rst_instret", bus.o_instret, 32'd0);
    check("rst_mis", 32'(bus.o_misaligned), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    idle(); idle();
    check("boot_done_valid", 32'(bus.o_valid), 32'd1);
    idle();
    check("instr_at_4", bus.o_instr, 32'hf00015b7);
    idle();
    check("pc_at_8", bus.o_pc, 32'h8);
    cycle(1'b0, 1'b1, 32'h2C, 1'b1, 32'h40, 1'b0, 1'b0);
    check("jump_wins_pc", bus.o_pc, 32'h2C);
    check("jump_wins_instr", bus.o_instr, 32'h001c0c13);
    check("instret_3", bus.o_instret, 32'd3);

    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
    check("stall_pc", bus.o_pc, 32'h10);
    check("stall_instret", bus.o_instret, 32'd4);

    cycle(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("halted", 32'(bus.o_halted), 32'd1);
    cycle(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0);
    check("halt_pc_hold", bus.o_pc, 32'h300);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("resume_pc", bus.o_pc, 32'h304);

    cycle(1'b0, 1'b1, 32'h2E, 1'b0, 32'h0, 1'b0, 1'b0);
    check("misaligned_pc", bus.o_pc, TRAP_EN ? 32'h100 : 32'h2C);
    idle();
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h33, 1'b0, 1'b0);

    cycle(1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 1'b0);
    idle();
    check("pc_wrap", bus.o_pc, 32'h0);
    cycle(1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a redirect request.
    drive(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_pc", bus.o_pc, 32'h0);
    check("async_rst_instret", bus.o_instret, 32'd0);
    check("async_rst_valid", 32'(bus.o_valid), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check("rst_hold_pc", bus.o_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(); idle(); idle();
    check("post_rst_pc", bus.o_pc, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
